// File: rtl/score_disp_pkg.sv
// Shared types and 7-segment helpers for the score display block.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package score_disp_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} conv_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_LUT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    return (d < 4'd10) ? SEG_LUT[d] : SEG_BLANK;
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift per clock, SCORE_W shifts per conversion.
// done pulses for the single LOAD cycle while bcd holds the finished result.
module bin2bcd_seq
  import score_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCORE_W    = 14
) (
  input  logic                    clk,
  input  logic                    clear_n,
  input  logic                    start,
  input  logic [SCORE_W-1:0]      bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  localparam int CNT_W = $clog2(SCORE_W + 1);

  conv_state_t             state;
  logic [SCORE_W-1:0]      sh;
  logic [CNT_W-1:0]        cnt;
  logic [4*NUM_DIGITS-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
      bcd   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sh    <= bin;
          bcd   <= '0;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          // Top BCD bit always drops out as zero: the value fits NUM_DIGITS digits.
          {bcd, sh} <= {adj[4*NUM_DIGITS-2:0], sh, 1'b0};
          cnt       <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(SCORE_W - 1)) begin
            done  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/score_display_scan.sv
// Saturating score accumulator, BCD conversion hand-off and multiplexed 7-seg scan.
// Optional macro LEADING_ZERO_BLANK_EN blanks zero digits above the most significant non-zero one.
module score_display_scan
  import score_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCORE_W    = 14,
  parameter int DELTA_W    = 4,
  parameter int PRESCALE_W = 17
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic                  add_valid,
  input  logic [DELTA_W-1:0]    add_delta,
  input  logic                  score_clr,
  input  logic                  disp_en,
  output logic [SCORE_W-1:0]    score,
  output logic                  saturated,
  output logic                  busy,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an
);

  localparam longint unsigned DEC_MAX = pow10(NUM_DIGITS) - 64'd1;
  localparam longint unsigned BIN_MAX = (64'd1 << SCORE_W) - 64'd1;
  localparam logic [SCORE_W-1:0] MAX  = SCORE_W'((DEC_MAX < BIN_MAX) ? DEC_MAX : BIN_MAX);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [SCORE_W:0]        sum;
  logic [SCORE_W-1:0]      score_nxt;
  logic                    dirty;
  logic                    conv_start;
  logic                    conv_done;
  logic [4*NUM_DIGITS-1:0] conv_bcd;
  logic [4*NUM_DIGITS-1:0] disp_bcd;
  logic [PRESCALE_W-1:0]   presc;
  logic [IDX_W-1:0]        idx;
  logic [3:0]              cur_digit;
  logic [NUM_DIGITS-1:0]   blank;

  // Sum is one bit wider than the score so saturation never sees a wrapped value.
  always_comb begin
    sum       = {1'b0, score} + (SCORE_W+1)'(add_delta);
    score_nxt = score;
    if (score_clr)      score_nxt = '0;
    else if (add_valid) score_nxt = (sum > {1'b0, MAX}) ? MAX : sum[SCORE_W-1:0];
  end

  // A change landing on the same edge as a snapshot keeps dirty set, so it is reconverted.
  assign conv_start = dirty && !busy;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      score <= '0;
      dirty <= 1'b0;
    end else begin
      score <= score_nxt;
      if (score_nxt != score) dirty <= 1'b1;
      else if (conv_start)    dirty <= 1'b0;
    end
  end

  assign saturated = (score == MAX);
  assign dp        = 1'b1;

  bin2bcd_seq #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCORE_W    (SCORE_W)
  ) u_bcd (
    .clk     (clk),
    .clear_n (clear_n),
    .start   (conv_start),
    .bin     (score),
    .busy    (busy),
    .done    (conv_done),
    .bcd     (conv_bcd)
  );

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)       disp_bcd <= '0;
    else if (conv_done) disp_bcd <= conv_bcd;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= presc + PRESCALE_W'(1);
      if (&presc) idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end
  end

  assign cur_digit = disp_bcd[4*idx +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  logic nz;
  always_comb begin
    blank = '0;
    nz    = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      nz       = nz | (disp_bcd[4*i +: 4] != 4'd0);
      blank[i] = !nz;
    end
  end
`else
  assign blank = '0;
`endif

  // seg and an share one register stage so a digit switch never shows the old pattern.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      seg <= SEG_BLANK;
      an  <= '1;
    end else begin
      seg <= blank[idx] ? SEG_BLANK : seg_decode(cur_digit);
      an  <= disp_en ? ~(NUM_DIGITS'(1) << idx) : '1;
    end
  end

endmodule

// File: tb/tb_score_display_scan.sv
// Directed bench for score_display_scan with a spec-level model checked every cycle.
// Honours LEADING_ZERO_BLANK_EN the same way the design does.
module tb_score_display_scan;

  localparam int ND = 4, SW = 14, DW = 4, PW = 2;
  localparam int MAXV   = 9999;
  localparam int SETTLE = 2 * SW + 6;

  logic          clk = 1'b0, clear_n = 1'b0;
  logic          add_valid = 1'b0, score_clr = 1'b0, disp_en = 1'b0;
  logic [DW-1:0] add_delta = '0;
  logic [SW-1:0] score;
  logic          saturated, busy, dp;
  logic [6:0]    seg;
  logic [ND-1:0] an;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  score_display_scan #(
    .NUM_DIGITS (ND), .SCORE_W (SW), .DELTA_W (DW), .PRESCALE_W (PW)
  ) dut (
    .clk (clk), .clear_n (clear_n), .add_valid (add_valid), .add_delta (add_delta),
    .score_clr (score_clr), .disp_en (disp_en), .score (score), .saturated (saturated),
    .busy (busy), .seg (seg), .dp (dp), .an (an)
  );

  // Expected 7-seg pattern for decimal digit d of value v.
  function automatic logic [6:0] pat(input int v, input int d);
    int p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && v < p) return 7'h7F;
`endif
    case ((v / p) % 10)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  default: return 7'h10;
    endcase
  endfunction

  function automatic logic [6:0] zero_hi();
`ifdef LEADING_ZERO_BLANK_EN
    return 7'h7F;
`else
    return 7'h40;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: score by arithmetic, scan digit from edges since reset, display trusted once settled.
  int            m_score = 0, m_k = 0, m_stable = 1000, m_dig = 0;
  logic [ND-1:0] m_an = '1;

  always @(posedge clk or negedge clear_n) begin
    int nxt;
    if (!clear_n) begin
      m_score = 0; m_k = 0; m_stable = 1000; m_an = '1; m_dig = 0;
    end else begin
      if (score_clr)      nxt = 0;
      else if (add_valid) nxt = (m_score + int'(add_delta) > MAXV) ? MAXV : m_score + int'(add_delta);
      else                nxt = m_score;
      m_stable = (nxt != m_score) ? 0 : ((m_stable < 1000) ? m_stable + 1 : 1000);
      m_score  = nxt;
      m_dig    = (m_k >> PW) % ND;
      m_an     = disp_en ? ~(ND'(1) << m_dig) : '1;
      m_k++;
    end
  end

  always @(negedge clk) begin
    chk("score", score, m_score);
    chk("saturated", saturated, m_score == MAXV);
    chk("dp", dp, 1);
    chk("an", an, m_an);
    if (m_k == 0) begin
      chk("rst_seg", seg, 7'h7F);
      chk("rst_busy", busy, 0);
    end else if (m_stable >= SETTLE) begin
      chk("seg", seg, pat(m_score, m_dig));
      chk("busy_idle", busy, 0);
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic add(input int d);
    add_valid = 1'b1; add_delta = DW'(d);
    step(1);
    add_valid = 1'b0; add_delta = '0;
  endtask

  task automatic wait_digit(input int d, input logic [6:0] exp, input string name);
    bit hit;
    hit = 0;
    for (int i = 0; i < 8 * ND && !hit; i++) begin
      @(negedge clk);
      if (an == ~(ND'(1) << d)) begin
        hit = 1;
        chk(name, seg, exp);
      end
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL %s: digit %0d never selected, an=%0h", name, d, an);
    end
  endtask

  initial begin
    // Reset values
    step(2);
    chk("t0_score", score, 0);
    chk("t0_an", an, 4'hF);
    chk("t0_seg", seg, 7'h7F);
    chk("t0_busy", busy, 0);
    clear_n = 1'b1; disp_en = 1'b1;
    step(3);

    // 1: reset in the middle of a conversion
    add(5);
    step(4);
    chk("t1_busy_pre", busy, 1);
    clear_n = 1'b0;
    #1;
    chk("t1_busy", busy, 0);
    chk("t1_an", an, 4'hF);
    chk("t1_seg", seg, 7'h7F);
    chk("t1_score", score, 0);
    step(2);
    clear_n = 1'b1;
    step(SETTLE);
    wait_digit(0, 7'h40, "t1_zero");

    // 2: three consecutive adds of 9
    add_valid = 1'b1; add_delta = 4'd9;
    step(3);
    add_valid = 1'b0; add_delta = '0;
    chk("t2_score", score, 27);
    step(SETTLE);
    wait_digit(0, 7'h78, "t2_d0");
    wait_digit(1, 7'h24, "t2_d1");
    wait_digit(2, zero_hi(), "t2_d2");
    wait_digit(3, zero_hi(), "t2_d3");

    // 4: second update while the first conversion is running
    score_clr = 1'b1; step(1); score_clr = 1'b0;
    step(SETTLE);
    add(5);
    @(negedge clk); chk("t4_busy_lat0", busy, 0);
    @(negedge clk); chk("t4_busy_lat1", busy, 1);
    step(2);
    add(3);
    chk("t4_score", score, 8);
    step(SETTLE);
    wait_digit(0, 7'h00, "t4_d0");

    // 5: leading digits of 42
    score_clr = 1'b1; step(1); score_clr = 1'b0;
    add(15); add(15); add(12);
    step(SETTLE);
    wait_digit(3, zero_hi(), "t5_d3");
    wait_digit(2, zero_hi(), "t5_d2");
    wait_digit(1, 7'h19, "t5_d1");
    wait_digit(0, 7'h24, "t5_d0");

    // 6: display disabled, scan keeps running
    disp_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("t6_an_off", an, 4'hF);
    end
    disp_en = 1'b1;
    step(8);

    // 3: saturation at 9999 and clear priority
    score_clr = 1'b1; step(1); score_clr = 1'b0;
    add_valid = 1'b1; add_delta = 4'd15;
    step(666);
    add_valid = 1'b0; add_delta = '0;
    add(5);
    chk("t3_preload", score, 9995);
    add(7);
    chk("t3_sat_score", score, 9999);
    chk("t3_sat_flag", saturated, 1);
    add(15);
    chk("t3_sat_hold", score, 9999);
    step(SETTLE);
    wait_digit(3, 7'h10, "t3_d3");
    score_clr = 1'b1; add_valid = 1'b1; add_delta = 4'd9;
    step(1);
    score_clr = 1'b0; add_valid = 1'b0; add_delta = '0;
    chk("t3_clr_score", score, 0);
    chk("t3_clr_flag", saturated, 0);
    step(SETTLE);
    wait_digit(0, 7'h40, "t3_d0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
